// File: rtl/seg7_scan_display_pkg.sv
// rtl/seg7_scan_display_pkg.sv - shared widths and segment constants for seg7_scan_display
package seg7_scan_display_pkg;

    // Width of the value written out by the core (RegBus).
    localparam int REG_BUS = 32;

    // Active-high gfedcba pattern for hex digits 0..F.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Inactive levels before polarity inversion (active-high view).
    localparam logic [6:0] SEG_OFF_HI = 7'h00;
    localparam logic       DP_OFF_HI  = 1'b0;

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational hex nibble to active-high gfedcba decoder
module seg7_hex_decode
    import seg7_scan_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup; polarity is applied by the caller.
    always_comb begin
        seg = HEX_SEG[nibble];
    end

endmodule

// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - 8-digit multiplexed seven-segment driver; SEG7_LZ_BLANK_EN enables leading-zero blanking
module seg7_scan_display
    import seg7_scan_display_pkg::*;
#(
    parameter int CLK_DIV        = 50000,
    parameter int DIGITS         = 8,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REG_BUS-1:0] data_i,
    input  logic               load_i,
    output logic [DIGITS-1:0]  an_o,
    output logic [6:0]         seg_o,
    output logic               dp_o,
    output logic               frame_o,
    output logic               valid_o
);

    localparam int              PW        = $clog2(CLK_DIV);
    localparam int              IW        = $clog2(DIGITS);
    localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0]   IDX_MAX   = IW'(DIGITS - 1);
    localparam logic [IW-1:0]   DP_IDX    = IW'(DIGITS / 2);

    // Polarity masks: XOR an active-high value with these to get the pin level.
    localparam logic [DIGITS-1:0] AN_POL  = (AN_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [6:0]        SEG_POL = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_POL  = (SEG_ACTIVE_LOW != 0);

    localparam logic [DIGITS-1:0] AN_OFF  = AN_POL;
    localparam logic [6:0]        SEG_OFF = SEG_OFF_HI ^ SEG_POL;
    localparam logic              DP_OFF  = DP_OFF_HI ^ DP_POL;

    logic [PW-1:0]      presc;
    logic [IW-1:0]      idx;
    logic [REG_BUS-1:0] shadow;
    logic [REG_BUS-1:0] disp;
    logic               pending;

    logic               tick;
    logic               wrap;
    logic [3:0]         nibble;
    logic [6:0]         seg_hi;
    logic [DIGITS-1:0]  an_hot;
    logic               blank;
    logic               lit;

    assign tick   = (presc == PRESC_MAX);
    assign wrap   = tick && (idx == IDX_MAX);
    assign nibble = disp[{idx, 2'b00} +: 4];
    assign an_hot = {{(DIGITS-1){1'b0}}, 1'b1} << idx;

`ifdef SEG7_LZ_BLANK_EN
    logic [REG_BUS-1:0] upper;

    // Digit is a leading zero when it and every higher nibble are zero; digit 0 never blanks.
    always_comb begin
        upper = disp >> {idx, 2'b00};
        blank = (idx != '0) && (upper == '0);
    end
`else
    assign blank = 1'b0;
`endif

    assign lit = valid_o && !blank;

    seg7_hex_decode u_hex_decode (
        .nibble (nibble),
        .seg    (seg_hi)
    );

    // Prescaler and digit index; frame_o marks the cycle after the last digit window ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc   <= '0;
            idx     <= '0;
            frame_o <= 1'b0;
        end else begin
            presc   <= tick ? '0 : presc + 1'b1;
            frame_o <= wrap;
            if (tick) begin
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end
        end
    end

    // Capture into shadow at any time, promote to disp only at a frame wrap so a scan never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow  <= '0;
            disp    <= '0;
            pending <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            if (wrap && pending) begin
                disp    <= shadow;
                valid_o <= 1'b1;
            end
            if (load_i) begin
                shadow  <= data_i;
                pending <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end
        end
    end

    // Registered pin drive from the current index and disp, blanked until the first value lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_o  <= AN_OFF;
            seg_o <= SEG_OFF;
            dp_o  <= DP_OFF;
        end else begin
            an_o  <= lit ? (an_hot ^ AN_POL) : AN_OFF;
            seg_o <= valid_o ? (seg_hi ^ SEG_POL) : SEG_OFF;
            dp_o  <= (lit && (idx == DP_IDX)) ? ~DP_OFF : DP_OFF;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb/tb_seg7_scan_display.sv - directed self-checking bench for seg7_scan_display
module tb_seg7_scan_display;

    logic        clk;
    logic        rst;
    logic [31:0] data_i;
    logic        load_i;
    logic [7:0]  an_o;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic        frame_o;
    logic        valid_o;

    int n_vec;
    int n_err;

`ifdef SEG7_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic [6:0] seg_tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    seg7_scan_display #(
        .CLK_DIV        (4),
        .DIGITS         (8),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data_i  (data_i),
        .load_i  (load_i),
        .an_o    (an_o),
        .seg_o   (seg_o),
        .dp_o    (dp_o),
        .frame_o (frame_o),
        .valid_o (valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " an"},    an_o,    32'hFF);
        check({tag, " seg"},   seg_o,   32'h7F);
        check({tag, " dp"},    dp_o,    32'h1);
        check({tag, " valid"}, valid_o, 32'h0);
        check({tag, " frame"}, frame_o, 32'h0);
    endtask

    // One 32-cycle frame starting right after a frame/reset edge; optional loads at steps la, lb.
    task automatic run_frame(input logic [31:0] val, input logic vis, input logic valid_end,
                             input int la, input logic [31:0] da,
                             input int lb, input logic [31:0] db);
        int         d;
        logic [3:0] nib;
        logic       on;
        logic [7:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        logic [31:0] upper;
        for (int k = 1; k <= 32; k++) begin
            load_i = (k == la) || (k == lb);
            data_i = (k == la) ? da : ((k == lb) ? db : 32'h0);
            step();
            load_i = 1'b0;
            d      = (k - 1) / 4;
            nib    = val[4*d +: 4];
            upper  = val >> (4 * d);
            on     = vis && (!LZ || d == 0 || upper != 32'h0);
            exp_an  = on ? ~(8'h01 << d) : 8'hFF;
            exp_seg = vis ? ~seg_tab[nib] : 7'h7F;
            exp_dp  = !(on && d == 4);
            check($sformatf("an %h d%0d", val, d),   an_o,    exp_an);
            check($sformatf("seg %h d%0d", val, d),  seg_o,   exp_seg);
            check($sformatf("dp %h d%0d", val, d),   dp_o,    exp_dp);
            check($sformatf("frame %h k%0d", val, k), frame_o, (k == 32));
            check($sformatf("valid %h k%0d", val, k), valid_o, (k == 32) ? valid_end : vis);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        rst    = 1'b1;
        load_i = 1'b0;
        data_i = 32'h0;

        // Reset held three cycles.
        for (int i = 0; i < 3; i++) begin
            step();
            check_reset_state("reset");
        end
        rst = 1'b0;

        // Blank frame with no load, then a mid-frame load taking effect at the wrap.
        run_frame(32'h0, 1'b0, 1'b0, 0, 32'h0, 0, 32'h0);
        run_frame(32'h0, 1'b0, 1'b1, 16, 32'h1234ABCD, 0, 32'h0);

        // Free run, every frame checked cycle by cycle.
        for (int f = 0; f < 6; f++) begin
            run_frame(32'h1234ABCD, 1'b1, 1'b1, 0, 32'h0, 0, 32'h0);
        end

        // Last load wins; load coincident with the wrap lands one frame later.
        run_frame(32'h1234ABCD, 1'b1, 1'b1, 5, 32'h11111111, 10, 32'h22222222);
        run_frame(32'h22222222, 1'b1, 1'b1, 3, 32'h44444444, 32, 32'h33333333);
        run_frame(32'h44444444, 1'b1, 1'b1, 0, 32'h0, 0, 32'h0);
        run_frame(32'h33333333, 1'b1, 1'b1, 0, 32'h0, 0, 32'h0);

        // Mid-scan reset with a pending load, which must be discarded.
        for (int k = 1; k <= 10; k++) begin
            load_i = (k == 3);
            data_i = 32'h55555555;
            step();
            load_i = 1'b0;
        end
        rst = 1'b1;
        step();
        check_reset_state("midrst");
        rst = 1'b0;
        run_frame(32'h0, 1'b0, 1'b0, 0, 32'h0, 0, 32'h0);

        // Leading-zero patterns (all digits lit unless blanking is built in).
        run_frame(32'h0, 1'b0, 1'b1, 8, 32'h000000A5, 0, 32'h0);
        run_frame(32'h000000A5, 1'b1, 1'b1, 10, 32'h00000000, 0, 32'h0);
        run_frame(32'h00000000, 1'b1, 1'b1, 0, 32'h0, 0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
